// File: rtl/bg_cpu_access.sv
// Z80 access arbiter for background tile RAM port B: a CPU access waits for a
// free renderer slot while BG_WAIT stretches the Z80 bus cycle.
module bg_cpu_access #(
    parameter int WAIT_MIN     = 2,
    parameter int SLOT_TIMEOUT = 64
) (
    input  logic        master_clk,
    input  logic        reset_n,
    input  logic        BACKGRAM_1,
    input  logic        BACKGRAM_2,
    input  logic        Z80_WR,
    input  logic        Z80_RD,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DIN,
    input  logic        BG_SYNC,
    input  logic [7:0]  BG_LO_q,
    input  logic [7:0]  BG_HI_q,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we_lo,
    output logic        ram_we_hi,
    output logic [7:0]  cpu_dout,
    output logic        BG_WAIT
);

    typedef enum logic [2:0] {IDLE, SYNC, ACCESS, CAPTURE, HOLD} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(SLOT_TIMEOUT - 1);
    localparam logic [3:0] WAIT_LAST    = 4'(WAIT_MIN - 1);

    state_t      state;
    state_t      state_next;
    logic        cs;
    logic        cs_q;
    logic        start;
    logic        load;
    logic        wait_q;
    logic        wait_next;
    logic [7:0]  timeout_cnt;
    logic [3:0]  wait_cnt;
    logic [10:0] addr_l;
    logic [7:0]  din_l;
    logic        sel_lo;
    logic        is_wr;
    logic        unused_addr_hi;

    // cs_q resets to "selected" so a select held through reset is not an edge
    assign cs             = !BACKGRAM_1 || !BACKGRAM_2;
    assign start          = cs && !cs_q && (!Z80_RD || !Z80_WR);
    assign unused_addr_hi = ^CPU_ADDR[15:11];

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_q;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SYNC;
                    wait_next  = 1'b0;
                    load       = 1'b1;
                end
            end
            SYNC: begin
                if (!cs) begin
                    state_next = IDLE;
                    wait_next  = 1'b1;
                end else if (BG_SYNC || timeout_cnt == TIMEOUT_LAST) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = HOLD;
                if (wait_cnt >= WAIT_LAST) begin
                    wait_next = 1'b1;
                end
            end
            HOLD: begin
                if (wait_cnt >= WAIT_LAST) begin
                    wait_next = 1'b1;
                end
                if (!cs) begin
                    state_next = IDLE;
                    wait_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                wait_next  = 1'b1;
            end
        endcase
    end

    // Both selects low resolves to the low byte; both strobes low to a write
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q        <= 1'b1;
            wait_q      <= 1'b1;
            timeout_cnt <= 8'd0;
            wait_cnt    <= 4'd0;
            addr_l      <= 11'd0;
            din_l       <= 8'd0;
            sel_lo      <= 1'b0;
            is_wr       <= 1'b0;
            cpu_dout    <= 8'd0;
        end else begin
            cs_q   <= cs;
            wait_q <= wait_next;
            if (load) begin
                addr_l      <= CPU_ADDR[10:0];
                din_l       <= CPU_DIN;
                sel_lo      <= !BACKGRAM_1;
                is_wr       <= !Z80_WR;
                timeout_cnt <= 8'd0;
                wait_cnt    <= 4'd0;
            end else begin
                if (state == SYNC && timeout_cnt != 8'hFF) begin
                    timeout_cnt <= timeout_cnt + 8'd1;
                end
                if (!wait_q && wait_cnt != 4'hF) begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end
            if (state == CAPTURE && !is_wr) begin
                cpu_dout <= sel_lo ? BG_LO_q : BG_HI_q;
            end
        end
    end

    assign ram_addr  = addr_l;
    assign ram_din   = din_l;
    assign ram_we_lo = (state == ACCESS) && is_wr && sel_lo;
    assign ram_we_hi = (state == ACCESS) && is_wr && !sel_lo;
    assign BG_WAIT   = wait_q;

endmodule

// File: tb/tb_bg_cpu_access.sv
// Randomised bench for bg_cpu_access: a driver predicts each access's RAM
// write and BG_WAIT release into a scoreboard that a negedge monitor drains.
module tb_bg_cpu_access;

    localparam int WAIT_MIN     = 5;
    localparam int SLOT_TIMEOUT = 64;

    logic        master_clk = 1'b0;
    logic        reset_n;
    logic        BACKGRAM_1;
    logic        BACKGRAM_2;
    logic        Z80_WR;
    logic        Z80_RD;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DIN;
    logic        BG_SYNC;
    logic [7:0]  BG_LO_q;
    logic [7:0]  BG_HI_q;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we_lo;
    logic        ram_we_hi;
    logic [7:0]  cpu_dout;
    logic        BG_WAIT;

    typedef struct {
        bit          is_release;
        logic [10:0] addr;
        logic [7:0]  data;
        bit          lo;
        int          cnt;
    } sb_event_t;

    sb_event_t   sb_q[$];
    sb_event_t   mon_ev;
    logic [7:0]  ram_lo [0:2047];
    logic [7:0]  ram_hi [0:2047];
    logic [7:0]  exp_lo [0:2047];
    logic [7:0]  exp_hi [0:2047];
    logic [7:0]  exp_dout = 8'd0;
    int          n_compared = 0;
    int          n_mismatch = 0;
    int          low_cnt = 0;

    bg_cpu_access #(
        .WAIT_MIN     (WAIT_MIN),
        .SLOT_TIMEOUT (SLOT_TIMEOUT)
    ) dut (
        .master_clk (master_clk),
        .reset_n    (reset_n),
        .BACKGRAM_1 (BACKGRAM_1),
        .BACKGRAM_2 (BACKGRAM_2),
        .Z80_WR     (Z80_WR),
        .Z80_RD     (Z80_RD),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_DIN    (CPU_DIN),
        .BG_SYNC    (BG_SYNC),
        .BG_LO_q    (BG_LO_q),
        .BG_HI_q    (BG_HI_q),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we_lo  (ram_we_lo),
        .ram_we_hi  (ram_we_hi),
        .cpu_dout   (cpu_dout),
        .BG_WAIT    (BG_WAIT)
    );

    always #5 master_clk = ~master_clk;

    // Port-B RAM pair with one-cycle read latency
    always @(posedge master_clk) begin
        if (ram_we_lo) ram_lo[ram_addr] = ram_din;
        if (ram_we_hi) ram_hi[ram_addr] = ram_din;
        BG_LO_q <= ram_lo[ram_addr];
        BG_HI_q <= ram_hi[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: low_cnt is the number of negedges BG_WAIT has been seen low
    always @(negedge master_clk) begin
        if (!BG_WAIT) low_cnt = low_cnt + 1;
        if (ram_we_lo || ram_we_hi) begin
            if (sb_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL unexpected_write: addr=0x%0h din=0x%0h, none expected", ram_addr, ram_din);
            end else begin
                mon_ev = sb_q.pop_front();
                checkOutput("event_is_release", 32'd0, 32'(mon_ev.is_release));
                checkOutput("write_addr", 32'(ram_addr), 32'(mon_ev.addr));
                checkOutput("write_data", 32'(ram_din), 32'(mon_ev.data));
                checkOutput("write_we_lo", 32'(ram_we_lo), 32'(mon_ev.lo));
                checkOutput("write_we_hi", 32'(ram_we_hi), 32'(!mon_ev.lo));
                checkOutput("write_cycle", 32'(low_cnt), 32'(mon_ev.cnt));
            end
        end
        if (BG_WAIT && low_cnt > 0) begin
            if (sb_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL unexpected_release: wait low %0d cycles, none expected", low_cnt);
            end else begin
                mon_ev = sb_q.pop_front();
                checkOutput("event_is_release", 32'd1, 32'(mon_ev.is_release));
                checkOutput("wait_low_cycles", 32'(low_cnt), 32'(mon_ev.cnt));
                checkOutput("cpu_dout", 32'(cpu_dout), 32'(mon_ev.data));
                checkOutput("ram_addr_held", 32'(ram_addr), 32'(mon_ev.addr));
            end
            low_cnt = 0;
        end
    end

    task automatic releaseBus();
        BACKGRAM_1 = 1'b1;
        BACKGRAM_2 = 1'b1;
        Z80_RD     = 1'b1;
        Z80_WR     = 1'b1;
    endtask

    // sel: 1 = BACKGRAM_1, 2 = BACKGRAM_2, 3 = both. n_low: cycles BG_SYNC
    // stays low after the start edge. abort_k / reset_edge: edge index after
    // which cs drops / reset pulses (negative = never).
    task automatic applyStimulus(input bit wr, input int sel, input bit both_strb,
                                 input logic [10:0] addr, input logic [7:0] data,
                                 input int n_low, input int abort_k, input int reset_edge);
        int        sync_cycles;
        int        dur;
        bit        lo;
        bit        done;
        logic [10:0] exp_addr;
        sb_event_t ev;

        sync_cycles = (n_low + 1 < SLOT_TIMEOUT) ? n_low + 1 : SLOT_TIMEOUT;
        lo          = (sel != 2);
        exp_addr    = addr;
        if (wr && abort_k < 0 && (reset_edge < 0 || reset_edge > sync_cycles)) begin
            ev = '{is_release: 1'b0, addr: addr, data: data, lo: lo, cnt: sync_cycles + 1};
            sb_q.push_back(ev);
            if (lo) exp_lo[addr] = data;
            else    exp_hi[addr] = data;
        end
        if (reset_edge > 0) begin
            dur      = reset_edge;
            exp_dout = 8'd0;
            exp_addr = 11'd0;
        end else if (abort_k >= 0) begin
            dur = abort_k + 1;
        end else begin
            dur = (sync_cycles + 2 > WAIT_MIN) ? sync_cycles + 2 : WAIT_MIN;
            if (!wr) exp_dout = lo ? exp_lo[addr] : exp_hi[addr];
        end
        ev = '{is_release: 1'b1, addr: exp_addr, data: exp_dout, lo: lo, cnt: dur};
        sb_q.push_back(ev);

        CPU_ADDR   = {5'($urandom), addr};
        CPU_DIN    = data;
        BACKGRAM_1 = (sel == 2);
        BACKGRAM_2 = (sel == 1);
        Z80_WR     = !wr;
        Z80_RD     = wr ? !both_strb : 1'b0;
        BG_SYNC    = (n_low == 0);
        @(posedge master_clk); #1;
        if (abort_k == 0) releaseBus();

        done = 1'b0;
        for (int j = 1; j <= 400; j++) begin
            if (j <= n_low)          BG_SYNC = 1'b0;
            else if (j == n_low + 1) BG_SYNC = 1'b1;
            else if (j == n_low + 2) BG_SYNC = 1'b0;
            else                     BG_SYNC = 1'($urandom);
            @(posedge master_clk); #1;
            if (j == reset_edge) begin
                reset_n = 1'b0;
                #1;
                checkOutput("reset_bg_wait", 32'(BG_WAIT), 32'd1);
                checkOutput("reset_we_lo", 32'(ram_we_lo), 32'd0);
                checkOutput("reset_we_hi", 32'(ram_we_hi), 32'd0);
                checkOutput("reset_cpu_dout", 32'(cpu_dout), 32'd0);
                @(posedge master_clk); #1;
                reset_n = 1'b1;
                repeat (3) begin
                    @(posedge master_clk); #1;
                    checkOutput("held_cs_no_start", 32'(BG_WAIT), 32'd1);
                end
                releaseBus();
                done = 1'b1;
                break;
            end
            if (j == abort_k) begin
                releaseBus();
            end else if (BG_WAIT) begin
                releaseBus();
                done = 1'b1;
                break;
            end
        end
        checkOutput("access_completes", 32'(done), 32'd1);
        repeat (2) @(posedge master_clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        int         n_low;
        int         abort_k;
        int         sel;
        bit         wr;

        for (int i = 0; i < 2048; i++) begin
            v = 8'($urandom); ram_lo[i] = v; exp_lo[i] = v;
            v = 8'($urandom); ram_hi[i] = v; exp_hi[i] = v;
        end
        ram_hi[11'h7FF] = 8'hC3;
        exp_hi[11'h7FF] = 8'hC3;

        reset_n  = 1'b0;
        releaseBus();
        CPU_ADDR = 16'd0;
        CPU_DIN  = 8'd0;
        BG_SYNC  = 1'b1;
        repeat (3) @(posedge master_clk);
        #1;
        checkOutput("rst_bg_wait", 32'(BG_WAIT), 32'd1);
        checkOutput("rst_we_lo", 32'(ram_we_lo), 32'd0);
        checkOutput("rst_we_hi", 32'(ram_we_hi), 32'd0);
        checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("rst_ram_din", 32'(ram_din), 32'd0);
        checkOutput("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge master_clk);
        #1;

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 1, 1'b0, 11'h123, 8'h5A, 0, -1, -1);
        applyStimulus(1'b0, 2, 1'b0, 11'h7FF, 8'h00, 10, -1, -1);
        applyStimulus(1'b1, 2, 1'b0, 11'h045, 8'hA7, 100, -1, -1);
        applyStimulus(1'b1, 1, 1'b0, 11'h200, 8'hEE, 20, 3, -1);
        applyStimulus(1'b0, 1, 1'b0, 11'h200, 8'h00, 0, -1, -1);
        applyStimulus(1'b0, 1, 1'b0, 11'h123, 8'h00, 0, -1, 4);
        applyStimulus(1'b1, 3, 1'b0, 11'h321, 8'h11, 1, -1, -1);
        applyStimulus(1'b0, 2, 1'b0, 11'h321, 8'h00, 0, -1, -1);
        applyStimulus(1'b1, 2, 1'b1, 11'h0AA, 8'h3C, 2, -1, -1);
        applyStimulus(1'b1, 1, 1'b0, 11'h0BB, 8'h99, 2, -1, 3);
        applyStimulus(1'b0, 1, 1'b0, 11'h0BB, 8'h00, 0, -1, -1);
        applyStimulus(1'b0, 2, 1'b1, 11'h0AA, 8'h00, 0, -1, -1);

        $display("[TB] random accesses");
        for (int i = 0; i < 40; i++) begin
            wr      = 1'($urandom);
            sel     = $urandom_range(1, 3);
            n_low   = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 4);
            abort_k = -1;
            if (n_low >= 1 && $urandom_range(0, 7) == 0)
                abort_k = $urandom_range(1, (n_low < 63) ? n_low : 63);
            applyStimulus(wr, sel, ($urandom_range(0, 3) == 0),
                          11'($urandom_range(0, 15)), 8'($urandom), n_low, abort_k, -1);
        end

        repeat (3) @(posedge master_clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/bg_cpu_access.md
BG_CPU_ACCESS -- requirements
Module: bg_cpu_access

Interface
REQ-001 Parameter WAIT_MIN, default 2: minimum master_clk cycles BG_WAIT is held low per access, legal range 1..15.
REQ-002 Parameter SLOT_TIMEOUT, default 64: master_clk cycles spent in SYNC before an access is forced, legal range 8..255.
REQ-003 master_clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 BACKGRAM_1  in  1  active-low CPU select, low byte RAM.
REQ-006 BACKGRAM_2  in  1  active-low CPU select, high byte RAM.
REQ-007 Z80_WR  in  1  active-low CPU write strobe.
REQ-008 Z80_RD  in  1  active-low CPU read strobe.
REQ-009 CPU_ADDR  in  16  CPU address; only [10:0] used.
REQ-010 CPU_DIN  in  8  CPU write data.
REQ-011 BG_SYNC  in  1  active-low renderer fetch slot; RAM belongs to renderer while low.
REQ-012 BG_LO_q  in  8  low byte RAM port-B read data, one-cycle read latency.
REQ-013 BG_HI_q  in  8  high byte RAM port-B read data, one-cycle read latency.
REQ-014 ram_addr  out  11  RAM port-B address.
REQ-015 ram_din  out  8  RAM port-B write data.
REQ-016 ram_we_lo  out  1  active-high write enable, low byte RAM.
REQ-017 ram_we_hi  out  1  active-high write enable, high byte RAM.
REQ-018 cpu_dout  out  8  read data returned to CPU.
REQ-019 BG_WAIT  out  1  active-low Z80 wait request.

Function
REQ-020 cs = !BACKGRAM_1 | !BACKGRAM_2; an access starts on a registered 0->1 edge of cs with Z80_RD or Z80_WR low; a level-held cs never starts a second access.
REQ-021 State machine has states IDLE, SYNC, ACCESS, CAPTURE, HOLD.
REQ-022 IDLE->SYNC on an access start; in the same cycle BG_WAIT goes low, and CPU_ADDR[10:0], CPU_DIN, select and direction are latched.
REQ-023 SYNC->ACCESS on the first cycle with BG_SYNC high, or when the SLOT_TIMEOUT counter expires.
REQ-024 ACCESS lasts exactly 1 cycle; a write asserts ram_we_lo or ram_we_hi (selected byte only) for that single cycle with ram_addr/ram_din at the latched values.
REQ-025 ACCESS->CAPTURE; in CAPTURE a read loads cpu_dout from BG_LO_q (BACKGRAM_1) or BG_HI_q (BACKGRAM_2); a write leaves cpu_dout unchanged.
REQ-026 CAPTURE->HOLD; BG_WAIT goes high once at least WAIT_MIN cycles have elapsed since it went low, and never earlier than the HOLD entry.
REQ-027 HOLD->IDLE when cs deasserts; cpu_dout stays stable throughout HOLD.
REQ-028 If both selects are low at the edge, BACKGRAM_1 wins; one byte only is accessed.
REQ-029 If both RD and WR are low at the edge, the access is a write.
REQ-030 If cs drops during SYNC, the access is aborted: no write, BG_WAIT high next cycle, state IDLE.
REQ-031 If BG_SYNC falls in the same cycle the FSM enters ACCESS, the access still completes; it is never split.
REQ-032 Outside ACCESS both write enables are 0; ram_addr holds the last latched address.
REQ-033 Timeout counter is 8 bits, cleared on SYNC entry, saturating; WAIT_MIN counter is 4 bits, saturating.

Reset
REQ-034 While reset_n is low: state IDLE, BG_WAIT=1, ram_we_lo=ram_we_hi=0, ram_addr=0, ram_din=0, cpu_dout=0, counters=0, registered cs=1.
REQ-035 Reset asserted mid-access drops BG_WAIT and the write enables immediately (asynchronous); no write completes after release.
REQ-036 After reset_n rises, a cs already held low does not start an access until it is deasserted and asserted again.

Verification
REQ-037 Write 0x5A to 0x123 via BACKGRAM_1 with BG_SYNC high -> one-cycle ram_we_lo, ram_addr=0x123, ram_din=0x5A, ram_we_hi=0, BG_WAIT low for exactly WAIT_MIN cycles.
REQ-038 Read 0x7FF via BACKGRAM_2 with BG_HI_q=0xC3 while BG_SYNC is low for 10 cycles -> no ACCESS until BG_SYNC rises, cpu_dout=0xC3, BG_WAIT released after CAPTURE.
REQ-039 BG_SYNC held low for 100 cycles with a pending write -> ACCESS forced at cycle 64 of SYNC, write performed once.
REQ-040 cs deasserted 3 cycles into SYNC -> no write enable, BG_WAIT high next cycle, FSM back in IDLE.
REQ-041 reset_n pulsed low during HOLD of a read -> BG_WAIT=1 and cpu_dout=0 at once; a subsequent access completes normally.
REQ-042 Both selects low during a write of 0x11 -> only ram_we_lo pulses.
